settings_batch_handler: RTL and testbench

SETTINGS_BATCH_HANDLER -- requirements
Module: settings_batch_handler

---
 rtl/settings_batch_handler.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_settings_batch_handler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/settings_batch_handler.sv
// Batch loader: reads {count, records} from a synchronous byte RAM, range-checks each record
// and commits it to settings_out. Optional macro SETTINGS_ATOMIC_EN: validate all, then re-read and commit.
module settings_batch_handler #(
    parameter int NUM_SETTINGS = 5,
    parameter int DATA_BYTES   = 4,
    parameter int MAX_RECORDS  = 8,
    parameter int ADDR_W       = 6,
    parameter logic [NUM_SETTINGS*32-1:0] LIMIT_MIN = {32'd5, 32'd0, 32'd0, 32'd1, 32'd1},
    parameter logic [NUM_SETTINGS*32-1:0] LIMIT_MAX = {32'd65535, 32'd15, 32'hFFFF_FFFF, 32'd32, 32'd32},
    parameter logic [NUM_SETTINGS*32-1:0] INIT_VAL  = {32'd10, 32'd65535, 32'd0, 32'd32, 32'd32}
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       clear_err,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [2:0]                 err_code,
    output logic [7:0]                 err_index,
    output logic                       ram_rd_en,
    output logic [ADDR_W-1:0]          ram_rd_addr,
    input  logic [7:0]                 ram_rd_data,
    output logic [NUM_SETTINGS*32-1:0] settings_out,
    output logic [NUM_SETTINGS-1:0]    settings_upd
);

    localparam int          REC_BYTES  = DATA_BYTES + 1;
    localparam int unsigned BUF_SIZE   = 2 ** ADDR_W;
    localparam logic [3:0]  PHASE_FIRST = 4'(DATA_BYTES + 1);
    localparam logic [7:0]  ID_MAX     = 8'(NUM_SETTINGS);
    localparam logic [7:0]  REC_MAX    = 8'(MAX_RECORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_CNT, S_CHK_CNT, S_FETCH_REC, S_CHK_REC, S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [3:0]                phase_q, phase_d;
    logic [ADDR_W-1:0]         ptr_q, ptr_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [7:0]                idx_q, idx_d;
    logic [7:0]                rec_id_q, rec_id_d;
    logic [31:0]               rec_val_q, rec_val_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      error_q, error_d;
    logic [2:0]                err_code_q, err_code_d;
    logic [7:0]                err_index_q, err_index_d;
    logic                      rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]         rd_addr_q, rd_addr_d;
    logic [NUM_SETTINGS*32-1:0] set_q, set_d;
    logic [NUM_SETTINGS-1:0]   upd_q, upd_d;
`ifdef SETTINGS_ATOMIC_EN
    logic                      pass_q, pass_d;
`endif

    logic [31:0]       rec_value, lim_min, lim_max, buf_span;
    logic              id_bad, val_bad;
    logic              begin_rec, fail, commit;
    logic [2:0]        fail_code;
    logic [7:0]        fail_idx;
    logic [ADDR_W-1:0] rec_base;

    // Data bytes are shifted in from the top, so narrow payloads need aligning down.
    always_comb begin
        rec_value = rec_val_q >> (8 * (4 - DATA_BYTES));
        lim_min   = '0;
        lim_max   = '0;
        for (int i = 0; i < NUM_SETTINGS; i++) begin
            if (rec_id_q == 8'(i + 1)) begin
                lim_min = LIMIT_MIN[i*32 +: 32];
                lim_max = LIMIT_MAX[i*32 +: 32];
            end
        end
        id_bad   = (rec_id_q == 8'd0) || (rec_id_q > ID_MAX);
        val_bad  = (rec_value < lim_min) || (rec_value > lim_max);
        buf_span = 32'(cnt_q) * 32'(REC_BYTES) + 32'd1;
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        rec_id_d    = rec_id_q;
        rec_val_d   = rec_val_q;
        error_d     = error_q;
        err_code_d  = err_code_q;
        err_index_d = err_index_q;
        set_d       = set_q;
        upd_d       = '0;
        rd_en_d     = 1'b0;
        rd_addr_d   = '0;
        begin_rec   = 1'b0;
        fail        = 1'b0;
        fail_code   = 3'd0;
        fail_idx    = 8'd0;
        commit      = 1'b0;
        rec_base    = ptr_q;
`ifdef SETTINGS_ATOMIC_EN
        pass_d      = pass_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (clear_err) begin
                    error_d     = 1'b0;
                    err_code_d  = 3'd0;
                    err_index_d = 8'd0;
                end
                if (start && (!error_q || clear_err)) begin
                    state_d = S_FETCH_CNT;
                    phase_d = 4'd1;
                    rd_en_d = 1'b1;
                    ptr_d   = ADDR_W'(1);
`ifdef SETTINGS_ATOMIC_EN
                    pass_d  = 1'b0;
`endif
                end
            end
            S_FETCH_CNT: begin
                if (phase_q != 4'd0) begin
                    phase_d = phase_q - 4'd1;
                end else begin
                    cnt_d   = ram_rd_data;
                    state_d = S_CHK_CNT;
                end
            end
            S_CHK_CNT: begin
                if (cnt_q == 8'd0 || cnt_q > REC_MAX) begin
                    fail      = 1'b1;
                    fail_code = 3'd1;
                end else if (buf_span > BUF_SIZE) begin
                    fail      = 1'b1;
                    fail_code = 3'd4;
                end else begin
                    idx_d     = 8'd0;
                    begin_rec = 1'b1;
                end
            end
            S_FETCH_REC: begin
                // Read issued in phase p returns in phase p-1: first return is the ID.
                if (phase_q == PHASE_FIRST - 4'd1) begin
                    rec_id_d = ram_rd_data;
                end else if (phase_q != PHASE_FIRST) begin
                    rec_val_d = {ram_rd_data, rec_val_q[31:8]};
                end
                if (phase_q >= 4'd2) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = ptr_q;
                    ptr_d     = ptr_q + ADDR_W'(1);
                end
                if (phase_q == 4'd0) begin
                    state_d = S_CHK_REC;
                end else begin
                    phase_d = phase_q - 4'd1;
                end
            end
            S_CHK_REC: begin
                if (id_bad) begin
                    fail      = 1'b1;
                    fail_code = 3'd2;
                    fail_idx  = idx_q;
                end else if (val_bad) begin
                    fail      = 1'b1;
                    fail_code = 3'd3;
                    fail_idx  = idx_q;
                end else begin
`ifdef SETTINGS_ATOMIC_EN
                    commit = pass_q;
                    if (idx_q == cnt_q - 8'd1) begin
                        if (!pass_q) begin
                            pass_d    = 1'b1;
                            idx_d     = 8'd0;
                            rec_base  = ADDR_W'(1);
                            begin_rec = 1'b1;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        idx_d     = idx_q + 8'd1;
                        begin_rec = 1'b1;
                    end
`else
                    commit = 1'b1;
                    if (idx_q == cnt_q - 8'd1) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d     = idx_q + 8'd1;
                        begin_rec = 1'b1;
                    end
`endif
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (commit) begin
            for (int i = 0; i < NUM_SETTINGS; i++) begin
                if (rec_id_q == 8'(i + 1)) begin
                    set_d[i*32 +: 32] = rec_value;
                    upd_d[i]          = 1'b1;
                end
            end
        end

        if (begin_rec) begin
            state_d   = S_FETCH_REC;
            phase_d   = PHASE_FIRST;
            rd_en_d   = 1'b1;
            rd_addr_d = rec_base;
            ptr_d     = rec_base + ADDR_W'(1);
            rec_id_d  = 8'd0;
            rec_val_d = 32'd0;
        end

        if (fail) begin
            state_d     = S_IDLE;
            error_d     = 1'b1;
            err_code_d  = fail_code;
            err_index_d = fail_idx;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            phase_q     <= 4'd0;
            ptr_q       <= '0;
            cnt_q       <= 8'd0;
            idx_q       <= 8'd0;
            rec_id_q    <= 8'd0;
            rec_val_q   <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= 3'd0;
            err_index_q <= 8'd0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            set_q       <= INIT_VAL;
            upd_q       <= '0;
`ifdef SETTINGS_ATOMIC_EN
            pass_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rec_id_q    <= rec_id_d;
            rec_val_q   <= rec_val_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
            err_index_q <= err_index_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            set_q       <= set_d;
            upd_q       <= upd_d;
`ifdef SETTINGS_ATOMIC_EN
            pass_q      <= pass_d;
`endif
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_code     = err_code_q;
    assign err_index    = err_index_q;
    assign ram_rd_en    = rd_en_q;
    assign ram_rd_addr  = rd_addr_q;
    assign settings_out = set_q;
    assign settings_upd = upd_q;

endmodule

// File: tb/tb_settings_batch_handler.sv
// Bench for settings_batch_handler: directed vector table, hand sequences (sticky error,
// mid-batch reset) and randomized batches against a record-level reference model.
module tb_settings_batch_handler;
    localparam int NS = 5, DB = 4, MAXR = 8, AW = 6;
`ifdef SETTINGS_ATOMIC_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    localparam bit ATOM = (PASSES == 2);

    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, clear_err = 1'b0;
    logic busy, done, error, ram_rd_en;
    logic [2:0] err_code;
    logic [7:0] err_index;
    logic [AW-1:0] ram_rd_addr;
    logic [7:0] ram_rd_data = 8'd0;
    logic [NS*32-1:0] settings_out;
    logic [NS-1:0] settings_upd;
    logic [7:0] mem [64];

    int unsigned lim_min [NS] = '{1, 1, 0, 0, 5};
    int unsigned lim_max [NS] = '{32, 32, 32'hFFFF_FFFF, 15, 65535};
    int unsigned init_v  [NS] = '{32, 32, 0, 65535, 10};
    int unsigned model_set [NS];

    int n_cmp = 0, n_fail = 0, idle_viol = 0;
    logic [2:0] m_code;
    logic [7:0] m_idx;
    int m_commits, m_lat;

    settings_batch_handler dut (
        .clk(clk), .rst(rst), .start(start), .clear_err(clear_err),
        .busy(busy), .done(done), .error(error), .err_code(err_code), .err_index(err_index),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .settings_out(settings_out), .settings_upd(settings_upd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    always @(negedge clk) if (!rst && !busy && (ram_rd_en || ram_rd_addr != '0)) idle_viol++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; clear_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_set = init_v;
    endtask

    // Reference: walk the records per the buffer layout; commits are staged for atomic mode.
    task automatic model_batch();
        int n, id, base;
        logic [31:0] v;
        int unsigned pend [NS];
        n = int'(mem[0]);
        m_code = 3'd0; m_idx = 8'd0; m_commits = 0; m_lat = 0;
        pend = model_set;
        if (n == 0 || n > MAXR) m_code = 3'd1;
        else if (1 + n * (DB + 1) > 2 ** AW) m_code = 3'd4;
        else begin
            for (int k = 0; k < n; k++) begin
                base = 1 + k * (DB + 1);
                id = int'(mem[base]);
                v = 32'd0;
                for (int b = 0; b < DB; b++) v = v | (32'(mem[base + 1 + b]) << (8 * b));
                if (id == 0 || id > NS) begin m_code = 3'd2; m_idx = 8'(k); break; end
                if (v < lim_min[id-1] || v > lim_max[id-1]) begin m_code = 3'd3; m_idx = 8'(k); break; end
                pend[id-1] = v;
                m_commits++;
            end
            if (m_code == 3'd0) m_lat = 4 + PASSES * n * (DB + 3);
        end
        if (ATOM && m_code != 3'd0) m_commits = 0;
        else model_set = pend;
    endtask

    task automatic run_batch(input bit allow_clear, output int lat, output int dcnt,
                             output int ucnt, output int bcnt, output bit ended);
        @(negedge clk);
        start = 1'b1;
        clear_err = allow_clear ? error : 1'b0;
        @(posedge clk); #1;
        start = 1'b0; clear_err = 1'b0;
        lat = 0; dcnt = 0; ucnt = 0; bcnt = 0; ended = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (done) begin dcnt++; if (lat == 0) lat = c; end
            ucnt += $countones(settings_upd);
            if (!busy) begin ended = 1'b1; break; end
            bcnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_settings(input string tag);
        for (int i = 0; i < NS; i++) chk({tag, "_set"}, settings_out[i*32 +: 32], model_set[i]);
    endtask

    task automatic model_run_check(input string tag);
        int lat, dcnt, ucnt, bcnt;
        bit ended;
        model_batch();
        run_batch(1'b1, lat, dcnt, ucnt, bcnt, ended);
        chk({tag, "_ended"}, ended, 1);
        chk({tag, "_error"}, error, m_code != 3'd0);
        chk({tag, "_code"}, err_code, m_code);
        chk({tag, "_index"}, err_index, m_idx);
        chk({tag, "_done_lat"}, lat, m_lat);
        chk({tag, "_done_cnt"}, dcnt, m_code == 3'd0);
        chk({tag, "_upd_cnt"}, ucnt, m_commits);
        check_settings(tag);
    endtask

    typedef struct packed {
        logic [127:0] buf_b;
        logic [7:0]   n_rec;
        logic [2:0]   code;
        logic [7:0]   idx;
        logic [2:0]   chk_id;
        logic [31:0]  chk_val;
        logic [7:0]   upd;
    } vec_t;

    function automatic logic [127:0] mkbuf(input logic [7:0] n,
        input logic [7:0] i0, input logic [31:0] v0, input logic [7:0] i1, input logic [31:0] v1,
        input logic [7:0] i2, input logic [31:0] v2);
        logic [127:0] b;
        b = '0;
        b[7:0] = n;
        b[8 +: 8] = i0;  b[16 +: 32] = v0;
        b[48 +: 8] = i1; b[56 +: 32] = v1;
        b[88 +: 8] = i2; b[96 +: 32] = v2;
        return b;
    endfunction

    task automatic load_buf(input logic [127:0] b);
        for (int a = 0; a < 64; a++) mem[a] = 8'd0;
        for (int a = 0; a < 16; a++) mem[a] = b[8*a +: 8];
    endtask

    task automatic gen_buffer();
        int n, r, id, sel, base;
        logic [31:0] v;
        for (int a = 0; a < 64; a++) mem[a] = 8'($urandom);
        r = $urandom_range(0, 19);
        if (r == 0) n = 0;
        else if (r == 1) n = $urandom_range(9, 255);
        else n = $urandom_range(1, MAXR);
        mem[0] = 8'(n);
        if (n >= 1 && n <= MAXR) begin
            for (int k = 0; k < n; k++) begin
                base = 1 + k * (DB + 1);
                r = $urandom_range(0, 29);
                if (r == 0) id = 0;
                else if (r == 1) id = $urandom_range(6, 255);
                else id = $urandom_range(1, NS);
                v = $urandom;
                if (id >= 1 && id <= NS) begin
                    sel = $urandom_range(0, 15);
                    case (sel)
                        0: v = lim_min[id-1];
                        1: v = lim_max[id-1];
                        2: v = lim_max[id-1] + 32'd1;
                        3: v = lim_min[id-1] - 32'd1;
                        15: v = $urandom;
                        default: v = 32'(longint'(lim_min[id-1]) +
                                 longint'($urandom) % (longint'(lim_max[id-1]) - longint'(lim_min[id-1]) + 1));
                    endcase
                end
                mem[base] = 8'(id);
                for (int b = 0; b < DB; b++) mem[base + 1 + b] = v[8*b +: 8];
            end
        end
    endtask

    vec_t vecs [11];

    initial begin
        int lat, dcnt, ucnt, bcnt, seen;
        bit ended;
        logic [127:0] bb;

        vecs[0]  = '{mkbuf(1, 5, 12, 0, 0, 0, 0), 8'd1, 3'd0, 8'd0, 3'd5, 32'd12, 8'd1};
        vecs[1]  = '{mkbuf(2, 1, 40, 2, 8, 0, 0), 8'd2, 3'd3, 8'd0, 3'd1, 32'd32, 8'd0};
        vecs[2]  = '{mkbuf(2, 2, 8, 7, 1, 0, 0), 8'd2, 3'd2, 8'd1, 3'd2, ATOM ? 32'd32 : 32'd8, ATOM ? 8'd0 : 8'd1};
        vecs[3]  = '{mkbuf(0, 1, 5, 0, 0, 0, 0), 8'd0, 3'd1, 8'd0, 3'd5, 32'd10, 8'd0};
        vecs[4]  = '{mkbuf(9, 1, 5, 1, 6, 1, 7), 8'd9, 3'd1, 8'd0, 3'd1, 32'd32, 8'd0};
        vecs[5]  = '{mkbuf(3, 4, 15, 3, 32'hFFFF_FFFF, 4, 7), 8'd3, 3'd0, 8'd0, 3'd4, 32'd7, 8'd3};
        vecs[6]  = '{mkbuf(1, 5, 5, 0, 0, 0, 0), 8'd1, 3'd0, 8'd0, 3'd5, 32'd5, 8'd1};
        vecs[7]  = '{mkbuf(1, 5, 4, 0, 0, 0, 0), 8'd1, 3'd3, 8'd0, 3'd5, 32'd10, 8'd0};
        vecs[8]  = '{mkbuf(2, 1, 31, 1, 33, 0, 0), 8'd2, 3'd3, 8'd1, 3'd1, ATOM ? 32'd32 : 32'd31, ATOM ? 8'd0 : 8'd1};
        vecs[9]  = '{mkbuf(1, 6, 1, 0, 0, 0, 0), 8'd1, 3'd2, 8'd0, 3'd1, 32'd32, 8'd0};
        vecs[10] = '{mkbuf(1, 4, 16, 0, 0, 0, 0), 8'd1, 3'd3, 8'd0, 3'd4, 32'd65535, 8'd0};

        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_code", err_code, 0);
        chk("rst_index", err_index, 0);
        chk("rst_rd_en", ram_rd_en, 0);
        chk("rst_rd_addr", ram_rd_addr, 0);
        chk("rst_upd", settings_upd, 0);
        check_settings("rst");

        for (int v = 0; v < 11; v++) begin
            do_reset();
            bb = vecs[v].buf_b;
            load_buf(bb);
            run_batch(1'b1, lat, dcnt, ucnt, bcnt, ended);
            chk($sformatf("vec%0d_ended", v), ended, 1);
            chk($sformatf("vec%0d_code", v), err_code, vecs[v].code);
            chk($sformatf("vec%0d_index", v), err_index, vecs[v].idx);
            chk($sformatf("vec%0d_error", v), error, vecs[v].code != 3'd0);
            chk($sformatf("vec%0d_done_lat", v), lat,
                (vecs[v].code == 3'd0) ? 4 + PASSES * int'(vecs[v].n_rec) * 7 : 0);
            chk($sformatf("vec%0d_upd_cnt", v), ucnt, vecs[v].upd);
            chk($sformatf("vec%0d_setting", v), settings_out[(int'(vecs[v].chk_id) - 1) * 32 +: 32], vecs[v].chk_val);
        end

        // Sticky error: start ignored until cleared; clear_err alone clears in IDLE.
        do_reset();
        load_buf(mkbuf(0, 0, 0, 0, 0, 0, 0));
        model_run_check("cnt0");
        load_buf(mkbuf(1, 3, 77, 0, 0, 0, 0));
        run_batch(1'b0, lat, dcnt, ucnt, bcnt, ended);
        chk("ignored_busy_cycles", bcnt, 0);
        chk("ignored_error", error, 1);
        chk("ignored_code", err_code, 1);
        @(negedge clk); clear_err = 1'b1;
        @(posedge clk); #1 clear_err = 1'b0;
        chk("clear_error", error, 0);
        chk("clear_code", err_code, 0);
        chk("clear_index", err_index, 0);
        model_run_check("after_clear");
        load_buf(mkbuf(9, 0, 0, 0, 0, 0, 0));
        model_run_check("cnt9");
        load_buf(mkbuf(2, 2, 20, 4, 3, 0, 0));
        model_run_check("clear_with_start");

        // Reset in the middle of record fetch.
        do_reset();
        load_buf(mkbuf(2, 3, 100, 4, 9, 0, 0));
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("mid_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_rd_en", ram_rd_en, 0);
        chk("mid_rd_addr", ram_rd_addr, 0);
        chk("mid_upd", settings_upd, 0);
        model_set = init_v;
        check_settings("mid");
        @(posedge clk); #1 rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("mid_no_activity", seen, 0);
        model_run_check("after_mid_rst");

        for (int r = 0; r < 60; r++) begin
            gen_buffer();
            model_run_check($sformatf("rnd%0d", r));
        end

        chk("idle_rd_quiet", idle_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
